// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard scoreboard for a multi-way in-order issue stage: decides the
// issuable prefix of each decode group and tracks per-register load latency.
module load_hazard_scoreboard #(
    parameter int WAYS      = 3,
    parameter int LOAD_LAT  = 1,
    parameter int INTRA_FWD = 0,
    localparam int CW       = $clog2(WAYS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic [WAYS-1:0]   id_valid,
    input  logic [5*WAYS-1:0] id_rs1,
    input  logic [5*WAYS-1:0] id_rs2,
    input  logic [WAYS-1:0]   id_use_rs1,
    input  logic [WAYS-1:0]   id_use_rs2,
    input  logic [5*WAYS-1:0] id_dest,
    input  logic [WAYS-1:0]   id_wr,
    input  logic [WAYS-1:0]   id_rd_mem,
    output logic [WAYS-1:0]   issue_mask,
    output logic [CW-1:0]     issue_count,
    output logic [CW-1:0]     rollback,
    output logic [15:0]       stall_cycles
);

    localparam logic [2:0] LAT3 = 3'(LOAD_LAT);

    logic [31:1][2:0] cnt;
    logic [31:1][2:0] cnt_nxt;
    logic [WAYS-1:0]  blocked;
    logic             open;
    logic [CW-1:0]    n_valid;
    logic [4:0]       wd;
    logic             stall_hit;

    function automatic logic src_haz(input logic use_en, input logic [4:0] idx,
                                     input logic [31:1][2:0] sb);
        return use_en && (idx != 5'd0) && (sb[idx] != 3'd0);
    endfunction

    // A way is blocked by being invalid, by a pending load on one of its
    // sources, or by an older same-group writer it cannot forward from.
    always_comb begin
        blocked = '0;
        for (int unsigned j = 0; j < WAYS; j++) begin
            if (!id_valid[j])
                blocked[j] = 1'b1;
            if (src_haz(id_use_rs1[j], id_rs1[5*j +: 5], cnt) ||
                src_haz(id_use_rs2[j], id_rs2[5*j +: 5], cnt))
                blocked[j] = 1'b1;
            for (int unsigned i = 0; i < j; i++) begin
                if (id_valid[i] && id_wr[i] && (id_dest[5*i +: 5] != 5'd0) &&
                    ((INTRA_FWD == 0) || id_rd_mem[i]) &&
                    ((id_use_rs1[j] && (id_rs1[5*j +: 5] == id_dest[5*i +: 5])) ||
                     (id_use_rs2[j] && (id_rs2[5*j +: 5] == id_dest[5*i +: 5]))))
                    blocked[j] = 1'b1;
            end
        end
    end

    always_comb begin
        issue_mask = '0;
        open       = reset && ex_ready && !flush;
        for (int unsigned j = 0; j < WAYS; j++) begin
            if (open && !blocked[j])
                issue_mask[j] = 1'b1;
            else
                open = 1'b0;
        end
    end

    always_comb begin
        issue_count = '0;
        n_valid     = '0;
        for (int unsigned j = 0; j < WAYS; j++) begin
            issue_count = issue_count + CW'(issue_mask[j]);
            n_valid     = n_valid + CW'(id_valid[j]);
        end
        rollback  = reset ? (n_valid - issue_count) : '0;
        stall_hit = ex_ready && id_valid[0] && (issue_count == '0);
    end

    // Ascending way order lets the youngest issued writer win on a shared dest.
    always_comb begin
        cnt_nxt = cnt;
        wd      = '0;
        if (ex_ready) begin
            for (int unsigned r = 1; r < 32; r++) begin
                if (cnt[5'(r)] != 3'd0)
                    cnt_nxt[5'(r)] = cnt[5'(r)] - 3'd1;
            end
        end
        for (int unsigned j = 0; j < WAYS; j++) begin
            wd = id_dest[5*j +: 5];
            if (issue_mask[j] && id_wr[j] && (wd != 5'd0))
                cnt_nxt[wd] = id_rd_mem[j] ? LAT3 : 3'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            cnt <= flush ? '0 : cnt_nxt;
            if (stall_hit && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Directed bench for load_hazard_scoreboard: three instances (no intra-group
// forwarding, intra-group forwarding, 3-cycle load latency) share one stimulus.
module tb_load_hazard_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        ex_ready;
    logic [2:0]  id_valid;
    logic [14:0] id_rs1, id_rs2, id_dest;
    logic [2:0]  id_use_rs1, id_use_rs2, id_wr, id_rd_mem;

    logic [2:0]  m0, m1, m3;
    logic [1:0]  c0, c1, c3, r0, r1, r3;
    logic [15:0] s0, s1, s3;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    load_hazard_scoreboard #(.WAYS(3), .LOAD_LAT(1), .INTRA_FWD(0)) u_dut (
        .clock(clock), .reset(reset), .flush(flush), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_dest(id_dest),
        .id_wr(id_wr), .id_rd_mem(id_rd_mem), .issue_mask(m0),
        .issue_count(c0), .rollback(r0), .stall_cycles(s0));

    load_hazard_scoreboard #(.WAYS(3), .LOAD_LAT(1), .INTRA_FWD(1)) u_fwd (
        .clock(clock), .reset(reset), .flush(flush), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_dest(id_dest),
        .id_wr(id_wr), .id_rd_mem(id_rd_mem), .issue_mask(m1),
        .issue_count(c1), .rollback(r1), .stall_cycles(s1));

    load_hazard_scoreboard #(.WAYS(3), .LOAD_LAT(3), .INTRA_FWD(0)) u_lat3 (
        .clock(clock), .reset(reset), .flush(flush), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_dest(id_dest),
        .id_wr(id_wr), .id_rd_mem(id_rd_mem), .issue_mask(m3),
        .issue_count(c3), .rollback(r3), .stall_cycles(s3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic idle();
        id_valid = '0; id_rs1 = '0; id_rs2 = '0; id_dest = '0;
        id_use_rs1 = '0; id_use_rs2 = '0; id_wr = '0; id_rd_mem = '0;
    endtask

    task automatic way_nop(input int unsigned w);
        id_valid[w] = 1'b1;
    endtask

    task automatic way_ld(input int unsigned w, input logic [4:0] d);
        id_valid[w] = 1'b1; id_dest[5*w +: 5] = d; id_wr[w] = 1'b1; id_rd_mem[w] = 1'b1;
    endtask

    task automatic way_alu(input int unsigned w, input logic [4:0] d);
        id_valid[w] = 1'b1; id_dest[5*w +: 5] = d; id_wr[w] = 1'b1; id_rd_mem[w] = 1'b0;
    endtask

    task automatic way_rd(input int unsigned w, input logic [4:0] a, input logic ua,
                          input logic [4:0] b, input logic ub);
        id_valid[w] = 1'b1;
        id_rs1[5*w +: 5] = a; id_use_rs1[w] = ua;
        id_rs2[5*w +: 5] = b; id_use_rs2[w] = ub;
    endtask

    // One flush cycle with nothing valid resynchronises all three scoreboards.
    task automatic resync();
        step(); idle(); flush = 1'b1;
        step(); flush = 1'b0;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        idle(); way_nop(0); way_nop(1); way_nop(2);
        #1;
        check("rst_mask", 32'(m0), 32'd0);
        check("rst_count", 32'(c0), 32'd0);
        check("rst_rollback", 32'(r0), 32'd0);
        check("rst_stall", 32'(s0), 32'd0);

        // load-use across groups
        step(); reset = 1'b1;
        idle(); way_ld(0, 5'd5); way_nop(1); way_nop(2);
        #1 check("ld5_issue", 32'(c0), 32'd3);
        step(); idle(); way_rd(0, 5'd5, 1'b1, 5'd0, 1'b0); way_nop(1); way_nop(2);
        #1 check("use5_count", 32'(c0), 32'd0);
        check("use5_rollback", 32'(r0), 32'd3);
        check("use5_lat3", 32'(c3), 32'd0);
        step();
        #1 check("use5_next", 32'(c0), 32'd3);
        check("use5_stall", 32'(s0), 32'd1);
        check("use5_lat3_next", 32'(c3), 32'd0);
        resync();

        // intra-group RAW
        idle(); way_alu(0, 5'd7); way_rd(1, 5'd7, 1'b1, 5'd0, 1'b0); way_nop(2);
        #1 check("intra_nofwd_mask", 32'(m0), 32'b001);
        check("intra_nofwd_rb", 32'(r0), 32'd2);
        check("intra_fwd_mask", 32'(m1), 32'b111);
        id_rd_mem[0] = 1'b1;
        #1 check("intra_fwd_load_mask", 32'(m1), 32'b001);
        resync();

        idle(); way_nop(0); way_nop(2);
        #1 check("hole_mask", 32'(m0), 32'b001);
        check("hole_rb", 32'(r0), 32'd1);

        // countdown holds while ex_ready is low
        step(); idle(); way_ld(0, 5'd9);
        step(); ex_ready = 1'b0; idle(); way_rd(0, 5'd9, 1'b1, 5'd0, 1'b0);
        #1 check("x9_hold_mask", 32'(m0), 32'd0);
        check("x9_hold_rb", 32'(r0), 32'd1);
        step(); step(); step();
        step(); ex_ready = 1'b1;
        #1 check("x9_first_ready", 32'(c0), 32'd0);
        step();
        #1 check("x9_second_ready", 32'(c0), 32'd1);
        check("x9_lat3", 32'(c3), 32'd0);
        check("x9_stall", 32'(s0), 32'd2);
        resync();

        // WAW kill and youngest-writer rule (visible with the 3-cycle instance)
        idle(); way_ld(0, 5'd3);
        step(); idle(); way_alu(0, 5'd3);
        #1 check("waw_add_issue", 32'(c3), 32'd1);
        step(); idle(); way_rd(0, 5'd3, 1'b1, 5'd0, 1'b0);
        #1 check("waw_reader_lat3", 32'(c3), 32'd1);
        check("waw_reader", 32'(c0), 32'd1);
        resync();
        idle(); way_alu(0, 5'd3); way_ld(1, 5'd3); way_nop(2);
        #1 check("grp_alu_ld_issue", 32'(c3), 32'd3);
        step(); idle(); way_rd(0, 5'd3, 1'b1, 5'd0, 1'b0);
        #1 check("grp_young_load", 32'(c3), 32'd0);
        resync();
        idle(); way_ld(0, 5'd3); way_alu(1, 5'd3);
        step(); idle(); way_rd(0, 5'd3, 1'b1, 5'd0, 1'b0);
        #1 check("grp_young_alu", 32'(c3), 32'd1);
        resync();

        // flush discards pending loads
        idle(); way_ld(0, 5'd4); way_ld(1, 5'd6);
        step(); flush = 1'b1; idle();
        way_rd(0, 5'd4, 1'b1, 5'd0, 1'b0); way_rd(1, 5'd6, 1'b1, 5'd0, 1'b0);
        way_rd(2, 5'd4, 1'b1, 5'd6, 1'b1);
        #1 check("flush_mask", 32'(m0), 32'd0);
        check("flush_rb", 32'(r0), 32'd3);
        step(); flush = 1'b0;
        #1 check("post_flush_lat3", 32'(c3), 32'd3);
        check("post_flush", 32'(c0), 32'd3);

        // x0 never hazards
        step(); idle(); way_ld(0, 5'd0);
        step(); idle(); way_alu(0, 5'd0);
        way_rd(1, 5'd0, 1'b1, 5'd0, 1'b1); way_rd(2, 5'd0, 1'b1, 5'd0, 1'b0);
        #1 check("x0_nofwd", 32'(m0), 32'b111);
        id_rd_mem[0] = 1'b1;
        #1 check("x0_fwd_load", 32'(m1), 32'b111);
        check("x0_nofwd_load", 32'(m0), 32'b111);

        // asynchronous reset between edges
        step(); idle(); way_ld(0, 5'd5);
        step(); idle(); way_rd(0, 5'd5, 1'b1, 5'd0, 1'b0);
        #2 reset = 1'b0;
        #1 check("async_stall", 32'(s0), 32'd0);
        check("async_mask", 32'(m3), 32'd0);
        check("async_rb", 32'(r0), 32'd0);
        reset = 1'b1;
        #1 check("post_rst_lat3", 32'(c3), 32'd1);
        check("post_rst", 32'(c0), 32'd1);

        // stall counter and saturation
        step(); idle(); way_nop(0); flush = 1'b1;
        step(); step(); step();
        #1 check("stall_three", 32'(s0), 32'd3);
        repeat (70000) step();
        #1 check("stall_sat", 32'(s0), 32'hFFFF);
        check("stall_sat_lat3", 32'(s3), 32'hFFFF);
        flush = 1'b0; idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_hazard_scoreboard.md
LOAD_HAZARD_SCOREBOARD -- requirements
Module: load_hazard_scoreboard

Interface
REQ-001 Parameter WAYS, default 3: issue group width, 1..8.
REQ-002 Parameter LOAD_LAT, default 1: cycles a load destination stays unforwardable after issue, 1..7.
REQ-003 Parameter INTRA_FWD, default 0: 0 = any intra-group RAW splits the group; 1 = only a RAW on a load producer splits it.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  squash; clears all scoreboard state.
REQ-007 ex_ready  in  1  downstream stage accepts an issue group this cycle.
REQ-008 id_valid  in  WAYS  per-way instruction valid; way 0 is oldest.
REQ-009 id_rs1, id_rs2  in  WAYS x 5  per-way source register indices.
REQ-010 id_use_rs1, id_use_rs2  in  WAYS  per-way source-read enables.
REQ-011 id_dest  in  WAYS x 5  per-way destination index.
REQ-012 id_wr  in  WAYS  per-way writes id_dest.
REQ-013 id_rd_mem  in  WAYS  per-way instruction is a load.
REQ-014 issue_mask  out  WAYS  ways issued this cycle; always a contiguous prefix from way 0.
REQ-015 issue_count  out  clog2(WAYS+1)  population count of issue_mask.
REQ-016 rollback  out  clog2(WAYS+1)  number of valid ways not issued: count of valid ways minus issue_count.
REQ-017 stall_cycles  out  16  saturating count of cycles with ex_ready=1, id_valid[0]=1 and issue_count=0.

Function
REQ-018 Scoreboard: one 3-bit countdown per register 1..31; register 0 has no entry and never hazards.
REQ-019 Source hazard: a source is hazarded when its read enable is 1, its index is nonzero, and its countdown is nonzero.
REQ-020 Intra-group hazard, way j against an older way i < j: way i is valid with id_wr=1, id_dest[i] is nonzero and equals an enabled source of way j, and either INTRA_FWD=0 or id_rd_mem[i]=1.
REQ-021 Blocked way: the way is invalid, has a source hazard, or has an intra-group hazard against any older way.
REQ-022 Issue prefix: issue_mask covers ways 0..b-1, where b is the first blocked way (WAYS if none); combinational, same cycle.
REQ-023 ex_ready=0 or flush=1: issue_mask=0, issue_count=0.
REQ-024 Countdown on ex_ready=1: every nonzero countdown decrements by 1.
REQ-025 Countdown on ex_ready=0: all countdowns hold.
REQ-026 Load issue: an issued way with id_wr=1, id_rd_mem=1, id_dest!=0 sets countdown[id_dest]=LOAD_LAT; this overrides the decrement.
REQ-027 Non-load issue: an issued way with id_wr=1, id_rd_mem=0, id_dest!=0 clears countdown[id_dest] to 0 (WAW kill).
REQ-028 Same-destination writers in one group: the youngest issued writer determines the countdown.
REQ-029 flush=1 clears all countdowns to 0 at the next edge and takes priority over REQ-024 to REQ-027.
REQ-030 stall_cycles increments by 1 per qualifying cycle and holds at 16'hFFFF.
REQ-031 All outputs are combinational from inputs and scoreboard state; no output register.

Reset
REQ-032 reset=0 asynchronously clears all countdowns and stall_cycles to 0, without waiting for a clock edge.
REQ-033 While reset=0: issue_mask=0, issue_count=0, rollback=0.
REQ-034 Reset asserted mid-countdown discards all pending hazards; the first cycle after release issues with no scoreboard hazard.

Verification
REQ-035 Bench SHALL cover the following directed scenarios.
- WAYS=3, LOAD_LAT=1. Cycle 0: way0 issues load x5. Cycle 1: way0 reads x5. Required: cycle 1 issue_count=0, rollback=3; cycle 2 issue_count=3.
- INTRA_FWD=0. way0 `add x7`, way1 reads x7, way2 independent. Required: issue_mask=3'b001, rollback=2.
- Same group with INTRA_FWD=1. Required: issue_mask=3'b111.
- Same group with way0 changed to a load of x7 and INTRA_FWD=1. Required: issue_mask=3'b001.
- Load x9 issued, then ex_ready=0 for 4 cycles, then a reader of x9. Required: the reader is still blocked on the first ex_ready=1 cycle.
- Load x3 pending, then one group issues `add x3`. Required: next cycle a reader of x3 issues, because the WAW clears the countdown.
- Loads pending on x4 and x6. flush=1 for one cycle. Required: next cycle readers of x4 and x6 issue fully.
- Reset pulsed low between clock edges. Required: stall_cycles reads 0 immediately.
- Force 70000 stalled cycles. Required: stall_cycles=16'hFFFF.
- Source index x0 against a pending load on x0 and an x0 writer in an older way. Required: never blocks.
